// File: rtl/zap_decode_ldmstm_seq_pkg.sv
// Shared decode constants for the LDM/STM expansion sequencer: instruction field
// positions, block-transfer and data-processing opcodes, and micro-op builders.
package zap_decode_ldmstm_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEQ  = 2'd1,
        S_WB   = 2'd2
    } seq_state_t;

    localparam logic [2:0]  BLOCK_XFER_OP = 3'b100;
    localparam logic [1:0]  SDT_CLASS     = 2'b01;
    localparam logic [2:0]  DP_IMM_CLASS  = 3'b001;
    localparam logic [3:0]  OPC_ADD       = 4'b0100;
    localparam logic [3:0]  OPC_SUB       = 4'b0010;
    localparam logic [15:0] R15_ONLY      = 16'h8000;

    localparam int SB_HI   = 34;
    localparam int SB_LO   = 33;
    localparam int COND_HI = 31;
    localparam int COND_LO = 28;
    localparam int OP_HI   = 27;
    localparam int OP_LO   = 25;
    localparam int P_BIT   = 24;
    localparam int U_BIT   = 23;
    localparam int S_BIT   = 22;
    localparam int W_BIT   = 21;
    localparam int L_BIT   = 20;
    localparam int RN_HI   = 19;
    localparam int RN_LO   = 16;

    // Single-register LDR/STR, pre-indexed, immediate offset, no writeback.
    function automatic logic [34:0] make_sdt(
        input logic [1:0]  sb_hi,
        input logic        s_bit,
        input logic [3:0]  cond,
        input logic        u_bit,
        input logic        l_bit,
        input logic [3:0]  rb,
        input logic [3:0]  ri,
        input logic [11:0] imm
    );
        return {sb_hi, s_bit, cond, SDT_CLASS, 1'b0, 1'b1, u_bit, 1'b0, 1'b0,
                l_bit, rb, ri, imm};
    endfunction

    // Base update: ADD/SUB Rb, Rb, #imm8 with rotate 0 and flags untouched.
    function automatic logic [34:0] make_dp_imm(
        input logic [1:0] sb_hi,
        input logic       s_bit,
        input logic [3:0] cond,
        input logic [3:0] opc,
        input logic [3:0] rb,
        input logic [7:0] imm8
    );
        return {sb_hi, s_bit, cond, DP_IMM_CLASS, opc, 1'b0, rb, rb, 4'h0, imm8};
    endfunction

endpackage

// File: rtl/zap_decode_prio_enc16.sv
// Lowest-set-bit encoder and population count over a 16-bit register mask.
module zap_decode_prio_enc16 (
    input  logic [15:0] i_mask,
    output logic [3:0]  o_idx,
    output logic [4:0]  o_count
);

    always_comb begin
        o_idx   = 4'd0;
        o_count = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = 4'(i);
            end
        end
        for (int j = 0; j < 16; j++) begin
            o_count = o_count + {4'd0, i_mask[j]};
        end
    end

endmodule

// File: rtl/zap_decode_ldmstm_seq.sv
// Expands LDM/STM into single-register LDR/STR micro-ops plus an optional base
// writeback; freezes fetch and masks interrupts while a sequence is in flight.
//
// state  | meaning
// IDLE   | pass-through, or first micro-op of a new block transfer
// SEQ    | emitting the remaining register transfers
// WB     | emitting the base-register writeback ADD/SUB
module zap_decode_ldmstm_seq
    import zap_decode_ldmstm_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_fiq,
    input  logic        i_irq,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic        i_stall_from_issue,
    input  logic [34:0] i_instruction,
    input  logic        i_instruction_valid,
    output logic [34:0] o_instruction,
    output logic        o_instruction_valid,
    output logic        o_stall_from_decode,
    output logic        o_fiq,
    output logic        o_irq
);

    seq_state_t  state_q, state_d;
    logic [15:0] mask_q, mask_d;
    logic [4:0]  k_q, k_d;
    logic [4:0]  n_q, n_d;
    logic        wb_pending_q, wb_pending_d;

    logic [1:0]  sb_hi;
    logic [3:0]  cond;
    logic        p_bit, u_bit, s_bit, w_bit, l_bit;
    logic [3:0]  rb;
    logic [15:0] list;
    logic        is_block, wb_en, r15_late;

    assign sb_hi = i_instruction[SB_HI:SB_LO];
    assign cond  = i_instruction[COND_HI:COND_LO];
    assign p_bit = i_instruction[P_BIT];
    assign u_bit = i_instruction[U_BIT];
    assign s_bit = i_instruction[S_BIT];
    assign w_bit = i_instruction[W_BIT];
    assign l_bit = i_instruction[L_BIT];
    assign rb    = i_instruction[RN_HI:RN_LO];
    assign list  = i_instruction[15:0];

    assign is_block = (i_instruction[OP_HI:OP_LO] == BLOCK_XFER_OP) && (list != 16'h0);
    // A load that overwrites the base makes the writeback meaningless.
    assign wb_en    = w_bit & ~(l_bit & list[rb]);
    // PC load must observe the updated base, so it is deferred past the writeback.
    assign r15_late = l_bit & list[15] & wb_en;

    logic [15:0] cur_mask, rem_mask;
    logic [3:0]  idx;
    logic [4:0]  cnt, rem_cnt;
    logic [4:0]  n_eff, k_eff;
    logic        wb_eff;

    assign cur_mask = (state_q == S_IDLE) ? list : mask_q;

    zap_decode_prio_enc16 u_prio_enc (
        .i_mask  (cur_mask),
        .o_idx   (idx),
        .o_count (cnt)
    );

    assign n_eff    = (state_q == S_IDLE) ? cnt   : n_q;
    assign k_eff    = (state_q == S_IDLE) ? 5'd0  : k_q;
    assign wb_eff   = (state_q == S_IDLE) ? wb_en : wb_pending_q;
    assign rem_mask = cur_mask & ~(16'h1 << idx);
    assign rem_cnt  = cnt - 5'd1;

    logic [9:0]  k10, n10;
    logic        xfer_u, reoffset;
    logic [11:0] xfer_imm;
    logic [34:0] xfer_op, wb_op;
    logic        xfer_last, wb_next;
    seq_state_t  xfer_next_state;

    assign k10      = {5'd0, k_eff};
    assign n10      = {5'd0, n_eff};
    assign reoffset = r15_late && (idx == 4'd15);

    always_comb begin
        xfer_u   = u_bit;
        xfer_imm = 12'd0;
        case ({p_bit, u_bit})
            2'b01: begin
                xfer_u   = ~reoffset;
                xfer_imm = reoffset ? 12'd4 : {k10, 2'b00};
            end
            2'b11: begin
                xfer_u   = 1'b1;
                xfer_imm = reoffset ? 12'd0 : {k10 + 10'd1, 2'b00};
            end
            2'b00: begin
                xfer_u   = reoffset;
                xfer_imm = reoffset ? {n10, 2'b00} : {n10 - k10 - 10'd1, 2'b00};
            end
            default: begin
                xfer_u   = reoffset;
                xfer_imm = reoffset ? ({n10, 2'b00} - 12'd4) : {n10 - k10, 2'b00};
            end
        endcase

        xfer_op = make_sdt(sb_hi, s_bit, cond, xfer_u, l_bit, rb, idx, xfer_imm);
        wb_op   = make_dp_imm(sb_hi, s_bit, cond, u_bit ? OPC_ADD : OPC_SUB, rb,
                              {1'b0, n_eff, 2'b00});

        xfer_last = (rem_cnt == 5'd0) && !wb_eff;
        wb_next   = wb_eff && ((rem_cnt == 5'd0) || (r15_late && (rem_mask == R15_ONLY)));
        if (xfer_last) begin
            xfer_next_state = S_IDLE;
        end else if (wb_next) begin
            xfer_next_state = S_WB;
        end else begin
            xfer_next_state = S_SEQ;
        end
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        k_d          = k_q;
        n_d          = n_q;
        wb_pending_d = wb_pending_q;

        o_instruction       = i_instruction;
        o_instruction_valid = i_instruction_valid;
        o_stall_from_decode = 1'b0;
        o_irq               = i_irq;
        o_fiq               = i_fiq;

        case (state_q)
            S_IDLE: begin
                if (i_instruction_valid && is_block) begin
                    o_irq = 1'b0;
                    o_fiq = 1'b0;
                    if (r15_late && (list == R15_ONLY)) begin
                        o_instruction       = wb_op;
                        o_stall_from_decode = 1'b1;
                        state_d             = S_SEQ;
                        mask_d              = list;
                        k_d                 = 5'd0;
                        n_d                 = cnt;
                        wb_pending_d        = 1'b0;
                    end else begin
                        o_instruction       = xfer_op;
                        o_stall_from_decode = !xfer_last;
                        state_d             = xfer_next_state;
                        mask_d              = rem_mask;
                        k_d                 = k_eff + 5'd1;
                        n_d                 = n_eff;
                        wb_pending_d        = wb_eff;
                    end
                end
            end
            S_SEQ: begin
                o_irq               = 1'b0;
                o_fiq               = 1'b0;
                o_instruction       = xfer_op;
                o_stall_from_decode = 1'b1;
                if (i_instruction_valid) begin
                    o_stall_from_decode = !xfer_last;
                    state_d             = xfer_next_state;
                    mask_d              = rem_mask;
                    k_d                 = k_eff + 5'd1;
                end
            end
            S_WB: begin
                o_irq               = 1'b0;
                o_fiq               = 1'b0;
                o_instruction       = wb_op;
                o_stall_from_decode = 1'b1;
                if (i_instruction_valid) begin
                    o_stall_from_decode = (mask_q != 16'h0);
                    state_d             = (mask_q != 16'h0) ? S_SEQ : S_IDLE;
                    wb_pending_d        = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (i_clear_from_writeback || (!i_data_stall && i_clear_from_alu)) begin
            state_d      = S_IDLE;
            mask_d       = 16'h0;
            k_d          = 5'd0;
            n_d          = 5'd0;
            wb_pending_d = 1'b0;
        end else if (i_data_stall || i_stall_from_issue) begin
            state_d      = state_q;
            mask_d       = mask_q;
            k_d          = k_q;
            n_d          = n_q;
            wb_pending_d = wb_pending_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            mask_q       <= 16'h0;
            k_q          <= 5'd0;
            n_q          <= 5'd0;
            wb_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            k_q          <= k_d;
            n_q          <= n_d;
            wb_pending_q <= wb_pending_d;
        end
    end

endmodule

// File: tb/tb_zap_decode_ldmstm_seq.sv
// Directed vector bench for the LDM/STM expansion sequencer.
module tb_zap_decode_ldmstm_seq;

    logic        i_clk;
    logic        i_reset;
    logic        i_fiq;
    logic        i_irq;
    logic        i_clear_from_writeback;
    logic        i_data_stall;
    logic        i_clear_from_alu;
    logic        i_stall_from_issue;
    logic [34:0] i_instruction;
    logic        i_instruction_valid;
    logic [34:0] o_instruction;
    logic        o_instruction_valid;
    logic        o_stall_from_decode;
    logic        o_fiq;
    logic        o_irq;

    zap_decode_ldmstm_seq dut (
        .i_clk                  (i_clk),
        .i_reset                (i_reset),
        .i_fiq                  (i_fiq),
        .i_irq                  (i_irq),
        .i_clear_from_writeback (i_clear_from_writeback),
        .i_data_stall           (i_data_stall),
        .i_clear_from_alu       (i_clear_from_alu),
        .i_stall_from_issue     (i_stall_from_issue),
        .i_instruction          (i_instruction),
        .i_instruction_valid    (i_instruction_valid),
        .o_instruction          (o_instruction),
        .o_instruction_valid    (o_instruction_valid),
        .o_stall_from_decode    (o_stall_from_decode),
        .o_fiq                  (o_fiq),
        .o_irq                  (o_irq)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ctl bits: {reset, clear_wb, data_stall, clear_alu, stall_issue}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_SI   = 5'b00001;
    localparam logic [4:0] C_CALU = 5'b00010;
    localparam logic [4:0] C_DS   = 5'b00100;
    localparam logic [4:0] C_CWB  = 5'b01000;
    localparam logic [4:0] C_RST  = 5'b10000;

    localparam logic [34:0] STMIA  = 35'h0_E8A00016;
    localparam logic [34:0] LDMIA  = 35'h0_E8BD8010;
    localparam logic [34:0] ALUOP  = 35'h0_E0812003;
    localparam logic [34:0] EMPTY  = 35'h0_E8900000;
    localparam logic [34:0] LDMDB  = 35'h0_E931000A;
    localparam logic [34:0] STMDA  = 35'h4_E8420001;
    localparam logic [34:0] LDMIB1 = 35'h0_E9B38000;
    localparam logic [34:0] LDMDA  = 35'h0_E8338001;
    localparam logic [34:0] LDMDB5 = 35'h0_E9358004;
    localparam logic [34:0] STMIB  = 35'h0_E9A00006;

    typedef struct packed {
        logic [34:0] instr;
        logic        valid;
        logic        irq;
        logic        fiq;
        logic [4:0]  ctl;
        logic [34:0] e_instr;
        logic        e_valid;
        logic        e_stall;
        logic        e_irq;
        logic        e_fiq;
    } vec_t;

    vec_t tbl[$];
    int   n_pass;
    int   n_total;

    function automatic vec_t mk(input logic [34:0] instr, input logic valid,
                                input logic irq, input logic fiq, input logic [4:0] ctl,
                                input logic [34:0] e_instr, input logic e_valid,
                                input logic e_stall, input logic e_irq, input logic e_fiq);
        vec_t v;
        v.instr   = instr;
        v.valid   = valid;
        v.irq     = irq;
        v.fiq     = fiq;
        v.ctl     = ctl;
        v.e_instr = e_instr;
        v.e_valid = e_valid;
        v.e_stall = e_stall;
        v.e_irq   = e_irq;
        v.e_fiq   = e_fiq;
        return v;
    endfunction

    // Micro-op inside a sequence with irq/fiq driven high: expect them gated.
    function automatic vec_t sq(input logic [34:0] instr, input logic [4:0] ctl,
                                input logic [34:0] e_instr, input logic e_stall);
        return mk(instr, 1'b1, 1'b1, 1'b1, ctl, e_instr, 1'b1, e_stall, 1'b0, 1'b0);
    endfunction

    task automatic run(input vec_t v, input string nm);
        @(negedge i_clk);
        i_instruction       = v.instr;
        i_instruction_valid = v.valid;
        i_irq               = v.irq;
        i_fiq               = v.fiq;
        {i_reset, i_clear_from_writeback, i_data_stall, i_clear_from_alu,
         i_stall_from_issue} = v.ctl;
        #1;
        n_total++;
        if ({o_instruction, o_valid_stall_irq_fiq()} ===
            {v.e_instr, v.e_valid, v.e_stall, v.e_irq, v.e_fiq}) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got instr=%h valid=%b stall=%b irq=%b fiq=%b, want instr=%h valid=%b stall=%b irq=%b fiq=%b",
                     nm, o_instruction, o_instruction_valid, o_stall_from_decode, o_irq, o_fiq,
                     v.e_instr, v.e_valid, v.e_stall, v.e_irq, v.e_fiq);
        end
    endtask

    function automatic logic [3:0] o_valid_stall_irq_fiq();
        return {o_instruction_valid, o_stall_from_decode, o_irq, o_fiq};
    endfunction

    initial begin
        n_pass                 = 0;
        n_total                = 0;
        i_reset                = 1'b1;
        i_fiq                  = 1'b0;
        i_irq                  = 1'b0;
        i_clear_from_writeback = 1'b0;
        i_data_stall           = 1'b0;
        i_clear_from_alu       = 1'b0;
        i_stall_from_issue     = 1'b0;
        i_instruction          = 35'h0;
        i_instruction_valid    = 1'b0;
        repeat (3) @(posedge i_clk);

        // Reset state: idle, block instruction present but not valid.
        tbl.push_back(mk(STMIA, 1'b0, 1'b1, 1'b0, C_NONE, STMIA, 1'b0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(sq(STMIA, C_NONE, 35'h0_E5801000, 1'b1));
        tbl.push_back(sq(STMIA, C_NONE, 35'h0_E5802004, 1'b1));
        tbl.push_back(sq(STMIA, C_NONE, 35'h0_E5804008, 1'b1));
        tbl.push_back(sq(STMIA, C_NONE, 35'h0_E280000C, 1'b0));
        tbl.push_back(sq(LDMIA, C_NONE, 35'h0_E59D4000, 1'b1));
        tbl.push_back(sq(LDMIA, C_NONE, 35'h0_E28DD008, 1'b1));
        tbl.push_back(sq(LDMIA, C_NONE, 35'h0_E51DF004, 1'b0));
        tbl.push_back(mk(ALUOP, 1'b1, 1'b1, 1'b0, C_NONE, ALUOP, 1'b1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(EMPTY, 1'b1, 1'b0, 1'b1, C_NONE, EMPTY, 1'b1, 1'b0, 1'b0, 1'b1));
        tbl.push_back(sq(LDMDB, C_NONE, 35'h0_E5111008, 1'b1));
        tbl.push_back(sq(LDMDB, C_NONE, 35'h0_E5113004, 1'b0));
        tbl.push_back(sq(STMDA, C_NONE, 35'h5_E5020000, 1'b0));
        tbl.push_back(sq(LDMIB1, C_NONE, 35'h0_E2833004, 1'b1));
        tbl.push_back(sq(LDMIB1, C_NONE, 35'h0_E593F000, 1'b0));
        tbl.push_back(sq(LDMDA, C_NONE, 35'h0_E5130004, 1'b1));
        tbl.push_back(sq(LDMDA, C_NONE, 35'h0_E2433008, 1'b1));
        tbl.push_back(sq(LDMDA, C_NONE, 35'h0_E593F008, 1'b0));
        tbl.push_back(sq(LDMDB5, C_NONE, 35'h0_E5152008, 1'b1));
        tbl.push_back(sq(LDMDB5, C_NONE, 35'h0_E2455008, 1'b1));
        tbl.push_back(sq(LDMDB5, C_NONE, 35'h0_E595F004, 1'b0));
        tbl.push_back(sq(STMIB, C_NONE, 35'h0_E5801004, 1'b1));
        tbl.push_back(sq(STMIB, C_NONE, 35'h0_E5802008, 1'b1));
        tbl.push_back(sq(STMIB, C_NONE, 35'h0_E2800008, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i], $sformatf("vec%0d", i));
        end

        // Flush from ALU on the second micro-op, then a plain instruction.
        run(sq(STMIA, C_NONE, 35'h0_E5801000, 1'b1), "calu_first");
        run(sq(STMIA, C_CALU, 35'h0_E5802004, 1'b1), "calu_second");
        run(mk(ALUOP, 1'b1, 1'b0, 1'b1, C_NONE, ALUOP, 1'b1, 1'b0, 1'b0, 1'b1), "calu_pass");

        // Issue stall held three cycles on micro-op 2.
        run(sq(STMIA, C_NONE, 35'h0_E5801000, 1'b1), "si_first");
        for (int i = 0; i < 3; i++) begin
            run(sq(STMIA, C_SI, 35'h0_E5802004, 1'b1), $sformatf("si_hold%0d", i));
        end
        run(sq(STMIA, C_NONE, 35'h0_E5802004, 1'b1), "si_release");
        run(sq(STMIA, C_NONE, 35'h0_E5804008, 1'b1), "si_third");
        run(sq(STMIA, C_NONE, 35'h0_E280000C, 1'b0), "si_wb");

        // Data stall outranks the ALU flush.
        run(sq(STMIA, C_NONE, 35'h0_E5801000, 1'b1), "ds_first");
        run(sq(STMIA, C_DS | C_CALU, 35'h0_E5802004, 1'b1), "ds_calu");
        run(sq(STMIA, C_NONE, 35'h0_E5802004, 1'b1), "ds_held");
        run(sq(STMIA, C_NONE, 35'h0_E5804008, 1'b1), "ds_third");
        run(sq(STMIA, C_NONE, 35'h0_E280000C, 1'b0), "ds_wb");

        // Writeback flush outranks the data stall and restarts the block.
        run(sq(STMIA, C_NONE, 35'h0_E5801000, 1'b1), "cwb_first");
        run(sq(STMIA, C_CWB | C_DS, 35'h0_E5802004, 1'b1), "cwb_ds");
        run(sq(STMIA, C_NONE, 35'h0_E5801000, 1'b1), "cwb_restart");
        run(sq(STMIA, C_NONE, 35'h0_E5802004, 1'b1), "cwb_second");
        run(sq(STMIA, C_NONE, 35'h0_E5804008, 1'b1), "cwb_third");
        run(sq(STMIA, C_NONE, 35'h0_E280000C, 1'b0), "cwb_wb");

        // Valid drops while the writeback is pending: invalid, stalled, state held.
        run(sq(LDMIA, C_NONE, 35'h0_E59D4000, 1'b1), "vlo_first");
        run(mk(LDMIA, 1'b0, 1'b1, 1'b1, C_NONE, 35'h0_E28DD008, 1'b0, 1'b1, 1'b0, 1'b0),
            "vlo_gap");
        run(sq(LDMIA, C_NONE, 35'h0_E28DD008, 1'b1), "vlo_wb");
        run(sq(LDMIA, C_NONE, 35'h0_E51DF004, 1'b0), "vlo_pc");

        // Synchronous reset in the middle of a sequence.
        run(sq(STMIB, C_NONE, 35'h0_E5801004, 1'b1), "rst_first");
        run(sq(STMIB, C_RST, 35'h0_E5802008, 1'b1), "rst_second");
        run(mk(ALUOP, 1'b1, 1'b1, 1'b1, C_NONE, ALUOP, 1'b1, 1'b0, 1'b1, 1'b1), "rst_pass");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
